// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command controller: FSM states, opcodes, error codes,
// ASCII bytes and display codes, plus the small helpers used to decode bytes.
package uart_cmd_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARG     = 3'd1;
    localparam logic [2:0] ST_EOL     = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_SET  = 2'd1;
    localparam logic [1:0] OP_INC  = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_COMM    = 2'd1;
    localparam logic [1:0] ERR_PARSE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_I  = 8'h49;
    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [3:0] DISP_COMM = 4'd14;
    localparam logic [3:0] DISP_FAIL = 4'd15;

    function automatic logic is_term(input logic [7:0] b);
        return (b == CH_LF) || (b == CH_CR);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

    // Result of executing op on the current value; stays within 0-9.
    function automatic logic [3:0] exec_value(input logic [1:0] op, input logic [3:0] arg,
                                              input logic [3:0] cur);
        logic [3:0] nxt;
        nxt = cur;
        case (op)
            OP_SET:  nxt = arg;
            OP_INC:  nxt = (cur >= 4'd9) ? 4'd0 : cur + 4'd1;
            OP_CLR:  nxt = 4'd0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout for a partial command frame; only built with UART_CMD_TIMEOUT_EN.
// Down-counter reloaded by every received byte, expires at terminal count while armed.
`ifdef UART_CMD_TIMEOUT_EN
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = count_en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || clear || !count_en || expire) begin
            cnt <= CNT_LOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule
`endif

// File: rtl/uart_cmd_ctrl.sv
// Frames the uart_rx byte stream into S<d>/I/C commands and drives the value/LED display.
// Optional inter-byte timeout is enabled with the UART_CMD_TIMEOUT_EN macro.
//
// state   | meaning
// IDLE    | waiting for a command letter
// ARG     | 'S' seen, waiting for a digit
// EOL     | command complete, waiting for LF/CR
// EXEC    | one-cycle command strobe, value updates on exit
// DISCARD | bad frame, dropping bytes until LF/CR then reporting pend_err
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    output logic [3:0] cmd_arg,
    output logic       err_valid,
    output logic [1:0] err_code,
    output logic [3:0] value,
    output logic [3:0] disp_code,
    output logic       busy,
    output logic [3:0] led_res
);
    if (TIMEOUT_CYCLES < 2) begin : g_cfg_chk
        $error("uart_cmd_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    logic [2:0] state;
    logic [1:0] op_q;
    logic [3:0] arg_q;
    logic [1:0] pend_err;
    logic       tmo_expire;

    assign busy      = (state == ST_ARG) || (state == ST_EOL) || (state == ST_DISCARD);
    assign cmd_valid = (state == ST_EXEC);
    assign cmd_op    = cmd_valid ? op_q : OP_NONE;
    assign cmd_arg   = (cmd_valid && op_q == OP_SET) ? arg_q : 4'd0;
    assign led_res   = ~disp_code;

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid),
        .count_en(busy),
        .expire  (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_NONE;
            arg_q     <= 4'd0;
            pend_err  <= ERR_NONE;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            value     <= 4'd0;
            disp_code <= 4'd0;
        end else begin
            err_valid <= 1'b0;

            // The strobe cycle commits the result; a byte arriving now is parsed as in IDLE.
            if (state == ST_EXEC) begin
                value     <= exec_value(op_q, arg_q, value);
                disp_code <= exec_value(op_q, arg_q, value);
                err_code  <= ERR_NONE;
            end

            if (rx_err) begin
                state    <= ST_DISCARD;
                pend_err <= ERR_COMM;
            end else if (rx_valid) begin
                case (state)
                    ST_IDLE, ST_EXEC: begin
                        if (rx_data == CH_S) begin
                            state <= ST_ARG;
                            op_q  <= OP_SET;
                            arg_q <= 4'd0;
                        end else if (rx_data == CH_I) begin
                            state <= ST_EOL;
                            op_q  <= OP_INC;
                            arg_q <= 4'd0;
                        end else if (rx_data == CH_C) begin
                            state <= ST_EOL;
                            op_q  <= OP_CLR;
                            arg_q <= 4'd0;
                        end else if (is_term(rx_data)) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_DISCARD;
                            pend_err <= ERR_PARSE;
                        end
                    end
                    ST_ARG: begin
                        if (is_digit(rx_data)) begin
                            state <= ST_EOL;
                            arg_q <= rx_data[3:0];
                        end else if (is_term(rx_data)) begin
                            state     <= ST_IDLE;
                            err_valid <= 1'b1;
                            err_code  <= ERR_PARSE;
                            disp_code <= DISP_FAIL;
                        end else begin
                            state    <= ST_DISCARD;
                            pend_err <= ERR_PARSE;
                        end
                    end
                    ST_EOL: begin
                        if (is_term(rx_data)) begin
                            state <= ST_EXEC;
                        end else begin
                            state    <= ST_DISCARD;
                            pend_err <= ERR_PARSE;
                        end
                    end
                    ST_DISCARD: begin
                        if (is_term(rx_data)) begin
                            state     <= ST_IDLE;
                            err_valid <= 1'b1;
                            err_code  <= pend_err;
                            disp_code <= (pend_err == ERR_COMM) ? DISP_COMM : DISP_FAIL;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (tmo_expire) begin
                state     <= ST_IDLE;
                err_valid <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                disp_code <= DISP_FAIL;
            end else if (state == ST_EXEC) begin
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl; follows UART_CMD_TIMEOUT_EN to pick the timeout expectation.
module tb_uart_cmd_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       err_valid;
    logic [1:0] err_code;
    logic [3:0] value;
    logic [3:0] disp_code;
    logic       busy;
    logic [3:0] led_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_arg  (cmd_arg),
        .err_valid(err_valid),
        .err_code (err_code),
        .value    (value),
        .disp_code(disp_code),
        .busy     (busy),
        .led_res  (led_res)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    // Sends a full command and lets it commit; leaves the bench one cycle after EXEC.
    task automatic send_cmd(input logic [7:0] c, input logic [7:0] d, input logic has_arg);
        send_byte(c);
        if (has_arg) send_byte(d);
        send_byte(8'h0A);
        step();
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        step();
        step();

        check_val("rst_cmd_valid", cmd_valid, 0);
        check_val("rst_cmd_op",    cmd_op,    0);
        check_val("rst_cmd_arg",   cmd_arg,   0);
        check_val("rst_err_valid", err_valid, 0);
        check_val("rst_err_code",  err_code,  0);
        check_val("rst_value",     value,     0);
        check_val("rst_disp",      disp_code, 0);
        check_val("rst_busy",      busy,      0);
        check_val("rst_led",       led_res,   15);
        rst = 1'b0;
        step();

        // "S7\n"
        send_byte("S");
        check_val("s7_busy_arg", busy, 1);
        send_byte("7");
        send_byte(8'h0A);
        check_val("s7_cmd_valid", cmd_valid, 1);
        check_val("s7_cmd_op",    cmd_op,    1);
        check_val("s7_cmd_arg",   cmd_arg,   7);
        check_val("s7_value_pre", value,     0);
        step();
        check_val("s7_cmd_valid_off", cmd_valid, 0);
        check_val("s7_value",    value,     7);
        check_val("s7_disp",     disp_code, 7);
        check_val("s7_err_code", err_code,  0);
        check_val("s7_led",      led_res,   8);

        // 9 -> INC wraps to 0, then CLR
        send_cmd("S", "9", 1'b1);
        check_val("s9_value", value, 9);
        send_byte("I");
        send_byte(8'h0D);
        check_val("inc_cmd_op",  cmd_op,  2);
        check_val("inc_cmd_arg", cmd_arg, 0);
        step();
        check_val("inc_wrap_value", value, 0);
        send_byte("C");
        send_byte(8'h0A);
        check_val("clr_cmd_op",    cmd_op,    3);
        check_val("clr_err_valid", err_valid, 0);
        step();
        check_val("clr_value",      value,     0);
        check_val("clr_err_valid2", err_valid, 0);

        // parse errors keep value
        send_cmd("S", "5", 1'b1);
        send_byte("S");
        send_byte("X");
        check_val("sx_busy", busy, 1);
        send_byte(8'h0A);
        check_val("sx_cmd_valid", cmd_valid, 0);
        check_val("sx_err_valid", err_valid, 1);
        check_val("sx_err_code",  err_code,  2);
        check_val("sx_disp",      disp_code, 15);
        check_val("sx_value",     value,     5);
        send_byte("Q");
        check_val("q_err_valid_off", err_valid, 0);
        send_byte(8'h0A);
        check_val("q_err_valid", err_valid, 1);
        check_val("q_err_code",  err_code,  2);
        step();
        check_val("q_err_code_hold", err_code, 2);
        check_val("q_value",         value,    5);

        // "S" then terminator ends the frame at once
        send_byte("S");
        send_byte(8'h0D);
        check_val("s_cr_err_valid", err_valid, 1);
        check_val("s_cr_busy",      busy,      0);
        step();

        // comm error mid "S3"
        send_cmd("S", "2", 1'b1);
        check_val("s2_err_code", err_code, 0);
        send_byte("S");
        rx_err = 1'b1;
        step();
        rx_err = 1'b0;
        send_byte("3");
        check_val("comm_no_report_yet", err_valid, 0);
        send_byte(8'h0A);
        check_val("comm_err_valid", err_valid, 1);
        check_val("comm_err_code",  err_code,  1);
        check_val("comm_disp",      disp_code, 14);
        check_val("comm_led",       led_res,   1);
        check_val("comm_value",     value,     2);
        step();

        // same-cycle rx_valid+rx_err: terminator dropped
        send_cmd("C", 8'h00, 1'b0);
        check_val("c_err_code", err_code, 0);
        send_byte("S");
        rx_data  = 8'h0A;
        rx_valid = 1'b1;
        rx_err   = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        check_val("drop_err_valid", err_valid, 0);
        check_val("drop_busy",      busy,      1);
        send_byte(8'h0A);
        check_val("drop_err_valid2", err_valid, 1);
        check_val("drop_err_code",   err_code,  1);
        step();

        // empty line
        send_byte(8'h0A);
        check_val("empty_err_valid", err_valid, 0);
        check_val("empty_cmd_valid", cmd_valid, 0);
        check_val("empty_busy",      busy,      0);
        check_val("empty_err_code",  err_code,  1);

        // timeout after "S"
        send_byte("S");
`ifdef UART_CMD_TIMEOUT_EN
        begin
            int n = 0;
            for (int i = 1; i <= 40; i++) begin
                step();
                if (err_valid) begin
                    n = i;
                    break;
                end
            end
            check_val("tmo_cycles",   n,         16);
            check_val("tmo_err_code", err_code,  3);
            check_val("tmo_busy",     busy,      0);
            check_val("tmo_disp",     disp_code, 15);
        end
`else
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (err_valid) seen++;
            end
            check_val("notmo_err_seen", seen, 0);
            check_val("notmo_busy",     busy, 1);
        end
        send_byte(8'h0A);
        check_val("notmo_err_code", err_code, 2);
`endif
        step();

        // reset mid-frame
        send_cmd("S", "6", 1'b1);
        check_val("s6_value", value, 6);
        send_byte("S");
        rst = 1'b1;
        step();
        check_val("mid_rst_value",     value,     0);
        check_val("mid_rst_disp",      disp_code, 0);
        check_val("mid_rst_busy",      busy,      0);
        check_val("mid_rst_cmd_valid", cmd_valid, 0);
        check_val("mid_rst_err_code",  err_code,  0);
        rst = 1'b0;
        send_byte("4");
        check_val("post_rst_busy", busy, 1);
        send_byte(8'h0A);
        check_val("post_rst_err_valid", err_valid, 1);
        check_val("post_rst_err_code",  err_code,  2);
        check_val("post_rst_disp",      disp_code, 15);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
